// File: rtl/fp_mult_issue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fp_mult_issue                                                            |
// | Operand FIFO and issue FSM for an external floating-point multiplier,    |
// | with timeout and a registered result stage. Optional status counters    |
// | are built when FP_MULT_ISSUE_STATUS_EN is defined.                       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fp_mult_issue #(
  parameter int Mantissa_Size = 23,
  parameter int Exponent_Size = 8,
  parameter int Depth         = 4,
  parameter int Max_Wait      = 15
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [Mantissa_Size+Exponent_Size:0]   in_A,
  input  logic [Mantissa_Size+Exponent_Size:0]   in_B,
  output logic                                   mult_load,
  output logic                                   mult_enable,
  output logic [Mantissa_Size+Exponent_Size:0]   mult_A,
  output logic [Mantissa_Size+Exponent_Size:0]   mult_B,
  input  logic                                   mult_done,
  input  logic                                   mult_zero,
  input  logic                                   mult_overflow,
  input  logic                                   mult_underflow,
  input  logic                                   mult_NAN,
  input  logic [Mantissa_Size+Exponent_Size:0]   mult_result,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [Mantissa_Size+Exponent_Size:0]   out_result,
  output logic [5:0]                             out_flags,
  output logic [7:0]                             stat_ovf,
  output logic [7:0]                             stat_unf,
  output logic [7:0]                             stat_nan
);

  localparam int c_msb    = Mantissa_Size + Exponent_Size;
  localparam int c_ptr_w  = $clog2(Depth);
  localparam int c_wait_w = $clog2(Max_Wait + 1);
  localparam logic [c_ptr_w:0]    c_depth     = (c_ptr_w + 1)'(Depth);
  localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(Max_Wait - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EXEC = 2'd2,
    S_CAPT = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [c_msb:0]      r_fifo_a [Depth];
  logic [c_msb:0]      r_fifo_b [Depth];
  logic [c_ptr_w-1:0]  r_wr_ptr;
  logic [c_ptr_w-1:0]  r_rd_ptr;
  logic [c_ptr_w:0]    r_count;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;

  logic [c_msb:0]      r_mult_a;
  logic [c_msb:0]      r_mult_b;
  logic [c_wait_w-1:0] r_wait;
  logic                r_timeout;
  logic                w_timeout_hit;
  logic                w_capture;

  logic                r_out_valid;
  logic [c_msb:0]      r_out_result;
  logic [5:0]          r_out_flags;
  logic [c_msb:0]      w_cap_result;
  logic [5:0]          w_cap_flags;

  // Ready depends only on registered occupancy, so a full FIFO never accepts
  // even in a cycle where the FSM pops.
  assign w_full   = (r_count == c_depth);
  assign w_empty  = (r_count == '0);
  assign in_ready = !w_full;
  assign w_push   = in_valid && !w_full;
  assign w_pop    = (r_state == S_IDLE) && !w_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_a[r_wr_ptr] <= in_A;
      r_fifo_b[r_wr_ptr] <= in_B;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_ptr_w + 1)'(1);
        2'b01:   r_count <= r_count - (c_ptr_w + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_next        = r_state;
    mult_load     = 1'b0;
    mult_enable   = 1'b0;
    w_capture     = 1'b0;
    w_timeout_hit = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) w_next = S_LOAD;
      end
      S_LOAD: begin
        // done may still be high from the previous operation here
        mult_load   = 1'b1;
        mult_enable = 1'b1;
        w_next      = S_EXEC;
      end
      S_EXEC: begin
        mult_enable = 1'b1;
        if (mult_done) begin
          w_next = S_CAPT;
        end else if (r_wait == c_wait_last) begin
          w_next        = S_CAPT;
          w_timeout_hit = 1'b1;
        end
      end
      S_CAPT: begin
        if (!r_out_valid || out_ready) begin
          w_capture = 1'b1;
          w_next    = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_mult_a  <= '0;
      r_mult_b  <= '0;
      r_wait    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_pop) begin
        r_mult_a <= r_fifo_a[r_rd_ptr];
        r_mult_b <= r_fifo_b[r_rd_ptr];
      end
      if (r_state == S_LOAD) begin
        r_wait    <= '0;
        r_timeout <= 1'b0;
      end else if (r_state == S_EXEC) begin
        r_wait <= r_wait + c_wait_w'(1);
        if (w_timeout_hit) r_timeout <= 1'b1;
      end
    end
  end

  assign mult_A = r_mult_a;
  assign mult_B = r_mult_b;

  // A timed-out operation reports a zero result; sign follows the forced value.
  assign w_cap_result = r_timeout ? '0 : mult_result;
  assign w_cap_flags  = {r_timeout, mult_NAN, mult_underflow, mult_overflow,
                         mult_zero, w_cap_result[c_msb]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_flags  <= '0;
    end else if (w_capture) begin
      r_out_valid  <= 1'b1;
      r_out_result <= w_cap_result;
      r_out_flags  <= w_cap_flags;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_flags  = r_out_flags;

`ifdef FP_MULT_ISSUE_STATUS_EN
  logic [7:0] r_stat_ovf;
  logic [7:0] r_stat_unf;
  logic [7:0] r_stat_nan;

  // Saturating event counters, stepped once per captured result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_ovf <= '0;
      r_stat_unf <= '0;
      r_stat_nan <= '0;
    end else if (w_capture) begin
      if (mult_overflow  && (r_stat_ovf != 8'hFF)) r_stat_ovf <= r_stat_ovf + 8'd1;
      if (mult_underflow && (r_stat_unf != 8'hFF)) r_stat_unf <= r_stat_unf + 8'd1;
      if (mult_NAN       && (r_stat_nan != 8'hFF)) r_stat_nan <= r_stat_nan + 8'd1;
    end
  end

  assign stat_ovf = r_stat_ovf;
  assign stat_unf = r_stat_unf;
  assign stat_nan = r_stat_nan;
`else
  assign stat_ovf = 8'd0;
  assign stat_unf = 8'd0;
  assign stat_nan = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_mult_issue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fp_mult_issue                                                         |
// | Scoreboard bench for fp_mult_issue with a behavioural FP32 multiplier.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fp_mult_issue;

  localparam int MAX_WAIT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_A, in_B;
  logic        mult_load, mult_enable;
  logic [31:0] mult_A, mult_B;
  logic        mult_done, mult_zero, mult_overflow, mult_underflow, mult_NAN;
  logic [31:0] mult_result;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [5:0]  out_flags;
  logic [7:0]  stat_ovf, stat_unf, stat_nan;

  fp_mult_issue #(
    .Mantissa_Size(23), .Exponent_Size(8), .Depth(4), .Max_Wait(MAX_WAIT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_A(in_A), .in_B(in_B),
    .mult_load(mult_load), .mult_enable(mult_enable), .mult_A(mult_A), .mult_B(mult_B),
    .mult_done(mult_done), .mult_zero(mult_zero), .mult_overflow(mult_overflow),
    .mult_underflow(mult_underflow), .mult_NAN(mult_NAN), .mult_result(mult_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_flags(out_flags),
    .stat_ovf(stat_ovf), .stat_unf(stat_unf), .stat_nan(stat_nan)
  );

  always #5 clk = ~clk;

  // flags layout: {timeout, NAN, underflow, overflow, zero, sign}
  typedef struct packed {
    logic [31:0] res;
    logic [5:0]  flags;
    logic        fast;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  exp_t m_t, m_hold;
  logic m_pend;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic hang       = 1'b0;
  logic rand_ready = 1'b0;
  int   exp_ovf = 0, exp_unf = 0, exp_nan = 0;

  // FP32 product for operands whose mantissa uses only the top 4 fraction bits.
  function automatic exp_t fp_model(input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    logic s, an, ai, az, bn, bi, bz;
    int ea, eb, e, p, m;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    an = (ea == 255) && (a[22:0] != 0);
    ai = (ea == 255) && (a[22:0] == 0);
    az = (ea == 0);
    bn = (eb == 255) && (b[22:0] != 0);
    bi = (eb == 255) && (b[22:0] == 0);
    bz = (eb == 0);
    r.fast  = 1'b1;
    r.flags = 6'd0;
    if (an || bn || (ai && bz) || (az && bi)) begin
      r.res = 32'h7FC00000; r.flags[4] = 1'b1;
    end else if (ai || bi) begin
      r.res = {s, 8'hFF, 23'h0}; r.flags[2] = 1'b1;
    end else if (az || bz) begin
      r.res = {s, 31'h0}; r.flags[1] = 1'b1;
    end else begin
      r.fast = 1'b0;
      p = (16 + int'(a[22:19])) * (16 + int'(b[22:19]));
      e = ea + eb - 127;
      if (p >= 512) begin e = e + 1; m = (p - 512) << 14; end
      else          m = (p - 256) << 15;
      if (e >= 255)     begin r.res = {s, 8'hFF, 23'h0}; r.flags[2] = 1'b1; end
      else if (e <= 0)  begin r.res = {s, 31'h0};        r.flags[3] = 1'b1; end
      else              r.res = {s, e[7:0], m[22:0]};
    end
    r.flags[0] = r.res[31];
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    int k, e;
    logic s;
    logic [3:0] f;
    k = $urandom_range(0, 19);
    s = 1'($urandom_range(0, 1));
    f = 4'($urandom_range(0, 15));
    if (k == 0) return {s, 31'h0};
    if (k == 1) return {s, 8'hFF, 23'h0};
    if (k == 2) return {s, 8'hFF, 4'hC, 19'h0};
    if (k <= 5)      e = $urandom_range(1, 60);
    else if (k <= 8) e = $urandom_range(200, 254);
    else             e = $urandom_range(100, 154);
    return {s, e[7:0], f, 19'h0};
  endfunction

  function automatic logic [31:0] stat_req(input int v);
`ifdef FP_MULT_ISSUE_STATUS_EN
    return 32'(v);
`else
    return 32'(v & 0);
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Multiplier stand-in: special operands finish in the first EXEC cycle,
  // normal ones one cycle later; hang mode never raises done.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mult_done <= 1'b0; mult_result <= '0; mult_zero <= 1'b0;
      mult_overflow <= 1'b0; mult_underflow <= 1'b0; mult_NAN <= 1'b0;
      m_pend <= 1'b0;
    end else if (mult_load) begin
      m_t = fp_model(mult_A, mult_B);
      if (hang || !m_t.fast) begin
        mult_done <= 1'b0; mult_result <= '0; mult_zero <= 1'b0;
        mult_overflow <= 1'b0; mult_underflow <= 1'b0; mult_NAN <= 1'b0;
        m_pend <= !hang;
        m_hold <= m_t;
      end else begin
        mult_done <= 1'b1; mult_result <= m_t.res; mult_zero <= m_t.flags[1];
        mult_overflow <= m_t.flags[2]; mult_underflow <= m_t.flags[3];
        mult_NAN <= m_t.flags[4]; m_pend <= 1'b0;
      end
    end else if (m_pend && mult_enable) begin
      mult_done <= 1'b1; mult_result <= m_hold.res; mult_zero <= m_hold.flags[1];
      mult_overflow <= m_hold.flags[2]; mult_underflow <= m_hold.flags[3];
      mult_NAN <= m_hold.flags[4]; m_pend <= 1'b0;
    end
  end

  // Monitor: every output transfer pops and checks the oldest expectation.
  initial forever begin
    @(negedge clk);
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_output: got %h required no output", out_result);
      end else begin
        mon_e = sb.pop_front();
        check("result", out_result, mon_e.res);
        check("flags", 32'(out_flags), 32'(mon_e.flags));
        if (mon_e.flags[2] && exp_ovf < 255) exp_ovf++;
        if (mon_e.flags[3] && exp_unf < 255) exp_unf++;
        if (mon_e.flags[4] && exp_nan < 255) exp_nan++;
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int g;
    in_A = a; in_B = b; in_valid = 1'b1; g = 0;
    @(negedge clk);
    while (!in_ready && g < 500) begin @(negedge clk); g++; end
    if (g >= 500) begin
      n_checks++; n_fail++;
      $display("FAIL push_wait: in_ready got 0 required 1");
    end
    if (hang) begin e.res = '0; e.flags = 6'b100000; e.fast = 1'b0; end
    else e = fp_model(a, b);
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Latency is counted from the LOAD cycle to the first cycle out_valid is high.
  task automatic directed(input logic [31:0] a, input logic [31:0] b, input int lat);
    int g, l;
    push(a, b);
    g = 0;
    @(negedge clk);
    while (!mult_load && g < 50) begin @(negedge clk); g++; end
    l = 0;
    while (!out_valid && l < 100) begin @(negedge clk); l++; end
    check("latency", 32'(l), 32'(lat));
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 5000) begin @(negedge clk); g++; end
    if (g >= 5000) begin
      n_checks++; n_fail++;
      $display("FAIL drain: %0d results outstanding, required 0", sb.size());
    end
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_state();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_mult_load", 32'(mult_load), 32'd0);
    check("rst_mult_enable", 32'(mult_enable), 32'd0);
    check("rst_mult_A", mult_A, 32'd0);
    check("rst_mult_B", mult_B, 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_flags", 32'(out_flags), 32'd0);
    check("rst_stats", {8'd0, stat_ovf, stat_unf, stat_nan}, 32'd0);
  endtask

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; in_A = '0; in_B = '0; out_ready = 1'b1;
    #12;
    check_reset_state();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    directed(32'h40400000, 32'h40000000, 4);
    directed(32'h3F800000, 32'h00000000, 3);
    directed(32'h7F800000, 32'h40000000, 3);
    drain();
    check("stat_ovf_one", 32'(stat_ovf), stat_req(1));

    hang = 1'b1;
    directed(32'h40400000, 32'h40000000, MAX_WAIT + 2);
    drain();
    hang = 1'b0;

    // Backpressure: five pairs queue up behind a held result.
    out_ready = 1'b0;
    push(32'h3FC00000, 32'h3FC00000);
    push(32'h3FC00000, 32'h40000000);
    push(32'h40000000, 32'h40000000);
    push(32'h40400000, 32'h40000000);
    push(32'h3FC00000, 32'h40400000);
    @(negedge clk);
    check("in_ready_full", 32'(in_ready), 32'd0);
    repeat (12) @(negedge clk);
    check("held_valid", 32'(out_valid), 32'd1);
    check("held_result", out_result, 32'h40100000);
    check("capt_enable", 32'(mult_enable), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    rand_ready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      push(rand_op(), rand_op());
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    drain();
    check("stat_ovf_rand", 32'(stat_ovf), stat_req(exp_ovf));
    check("stat_unf_rand", 32'(stat_unf), stat_req(exp_unf));
    check("stat_nan_rand", 32'(stat_nan), stat_req(exp_nan));

    for (int i = 0; i < 258; i++) push(32'hFF800000, 32'h40000000);
    drain();
    check("stat_ovf_sat", 32'(stat_ovf), stat_req(exp_ovf));

    // Reset while one pair executes and two more wait in the FIFO.
    hang = 1'b1;
    push(32'h40400000, 32'h40000000);
    push(32'h3FC00000, 32'h3FC00000);
    push(32'h40000000, 32'h40000000);
    seen = 0;
    @(negedge clk);
    while (!(mult_enable && !mult_load) && seen < 50) begin @(negedge clk); seen++; end
    #2 rst = 1'b1;
    #1;
    check_reset_state();
    sb.delete();
    exp_ovf = 0; exp_unf = 0; exp_nan = 0;
    @(posedge clk);
    @(negedge clk); rst = 1'b0; hang = 1'b0;
    seen = 0;
    repeat (30) begin @(negedge clk); if (out_valid) seen++; end
    check("no_stale_valid", 32'(seen), 32'd0);
    check("post_rst_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    directed(32'h3FC00000, 32'h3FC00000, 4);
    drain();
    check("stat_ovf_post_rst", 32'(stat_ovf), stat_req(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
